// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: resolves branch redirects, multi-cycle
// mul/div occupancy of EX, load-use hazards and fetch bubbles under a fixed priority.
module pipeline_hazard_controller #(
   parameter int unsigned MULDIV_LATENCY = 4,
   parameter int unsigned STALL_CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             rs1_ID,
   input  logic [4:0]             rs2_ID,
   input  logic                   usesRs1_ID,
   input  logic                   usesRs2_ID,
   input  logic [4:0]             rd_EX,
   input  logic                   memRead_EX,
   input  logic                   muldivStart_EX,
   input  logic                   branchTaken_EX,
   input  logic                   imemReady,
   output logic                   pcEnable,
   output logic                   ifidEnable,
   output logic                   ifidClear,
   output logic                   idexEnable,
   output logic                   idexClear,
   output logic                   exmemClear,
   output logic                   muldivDone,
   output logic [STALL_CNT_W-1:0] stallCount
);

   localparam int unsigned CntW = ($clog2(MULDIV_LATENCY) > 1) ? $clog2(MULDIV_LATENCY) : 1;

   typedef enum logic [1:0] {
      StRun       = 2'd0,
      StMdBusy    = 2'd1,
      StMdRelease = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        md_remain_q, md_remain_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic rs1_hit, rs2_hit, load_use;
   logic md_entry, md_stall;

   assign rs1_hit  = usesRs1_ID && (rs1_ID == rd_EX);
   assign rs2_hit  = usesRs2_ID && (rs2_ID == rd_EX);
   assign load_use = memRead_EX && (rd_EX != 5'd0) && (rs1_hit || rs2_hit);
   assign md_entry = (state_q == StRun) && muldivStart_EX && !branchTaken_EX;
   assign md_stall = md_entry || (state_q == StMdBusy);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StRun;
         md_remain_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         md_remain_q <= md_remain_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Next-state logic; muldivStart_EX is only looked at in RUN since the same
   // instruction sits in EX for the whole busy/release sequence.
   always_comb begin
      state_d     = state_q;
      md_remain_d = md_remain_q;
      unique case (state_q)
         StRun: begin
            if (md_entry) begin
               if (MULDIV_LATENCY > 2) begin
                  state_d     = StMdBusy;
                  md_remain_d = CntW'(MULDIV_LATENCY - 2);
               end else begin
                  state_d = StMdRelease;
               end
            end
         end
         StMdBusy: begin
            if (md_remain_q == CntW'(1)) begin
               state_d = StMdRelease;
            end else begin
               md_remain_d = md_remain_q - CntW'(1);
            end
         end
         StMdRelease: state_d = StRun;
         default:     state_d = StRun;
      endcase
   end

   // Output logic, highest priority first
   always_comb begin
      pcEnable   = 1'b1;
      ifidEnable = 1'b1;
      ifidClear  = 1'b0;
      idexEnable = 1'b1;
      idexClear  = 1'b0;
      exmemClear = 1'b0;
      muldivDone = 1'b0;
      if (reset) begin
         pcEnable   = 1'b0;
         ifidEnable = 1'b0;
         idexEnable = 1'b0;
         ifidClear  = 1'b1;
         idexClear  = 1'b1;
         exmemClear = 1'b1;
      end else begin
         muldivDone = (state_q == StMdRelease);
         if (branchTaken_EX) begin
            // The branch itself retires, so EX/MEM keeps it.
            ifidClear = 1'b1;
            idexClear = 1'b1;
         end else if (md_stall) begin
            pcEnable   = 1'b0;
            ifidEnable = 1'b0;
            idexEnable = 1'b0;
            exmemClear = 1'b1;
         end else if (load_use) begin
            pcEnable   = 1'b0;
            ifidEnable = 1'b0;
            idexClear  = 1'b1;
         end else if (!imemReady) begin
            pcEnable  = 1'b0;
            ifidClear = 1'b1;
         end
      end
   end

   assign stall_cnt_d = pcEnable ? stall_cnt_q : stall_cnt_q + STALL_CNT_W'(1);
   assign stallCount  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: one instance at latency 4, one at latency 2.
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs1_ID, rs2_ID, rd_EX;
   logic       usesRs1_ID, usesRs2_ID, memRead_EX, muldivStart_EX, branchTaken_EX, imemReady;

   logic pc4, ife4, ifc4, ide4, idc4, exc4, done4;
   logic pc2, ife2, ifc2, ide2, idc2, exc2, done2;
   logic [15:0] cnt4, cnt2;
   logic [6:0]  o4, o2;

   int n_pass  = 0;
   int n_total = 0;

   // Output vector order: pcEn, ifidEn, ifidClr, idexEn, idexClr, exmemClr, muldivDone
   localparam logic [6:0] ORun   = 7'b1101000;
   localparam logic [6:0] ORst   = 7'b0010110;
   localparam logic [6:0] OLdUse = 7'b0001100;
   localparam logic [6:0] OBr    = 7'b1111100;
   localparam logic [6:0] OMd    = 7'b0000010;
   localparam logic [6:0] ODone  = 7'b1101001;
   localparam logic [6:0] OImem  = 7'b0111000;

   assign o4 = {pc4, ife4, ifc4, ide4, idc4, exc4, done4};
   assign o2 = {pc2, ife2, ifc2, ide2, idc2, exc2, done2};

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.MULDIV_LATENCY(4), .STALL_CNT_W(16)) dut (
      .clk(clk), .reset(reset), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
      .usesRs1_ID(usesRs1_ID), .usesRs2_ID(usesRs2_ID), .rd_EX(rd_EX),
      .memRead_EX(memRead_EX), .muldivStart_EX(muldivStart_EX),
      .branchTaken_EX(branchTaken_EX), .imemReady(imemReady),
      .pcEnable(pc4), .ifidEnable(ife4), .ifidClear(ifc4), .idexEnable(ide4),
      .idexClear(idc4), .exmemClear(exc4), .muldivDone(done4), .stallCount(cnt4)
   );

   pipeline_hazard_controller #(.MULDIV_LATENCY(2), .STALL_CNT_W(16)) dut2 (
      .clk(clk), .reset(reset), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
      .usesRs1_ID(usesRs1_ID), .usesRs2_ID(usesRs2_ID), .rd_EX(rd_EX),
      .memRead_EX(memRead_EX), .muldivStart_EX(muldivStart_EX),
      .branchTaken_EX(branchTaken_EX), .imemReady(imemReady),
      .pcEnable(pc2), .ifidEnable(ife2), .ifidClear(ifc2), .idexEnable(ide2),
      .idexClear(idc2), .exmemClear(exc2), .muldivDone(done2), .stallCount(cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle();
      rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
      usesRs1_ID = 1'b0; usesRs2_ID = 1'b0; memRead_EX = 1'b0;
      muldivStart_EX = 1'b0; branchTaken_EX = 1'b0; imemReady = 1'b1;
   endtask

   task automatic load_use_rs2(input logic [4:0] rd);
      memRead_EX = 1'b1; rd_EX = rd; rs2_ID = 5'd5; usesRs2_ID = 1'b1;
   endtask

   // Check the latency-4 outputs mid-cycle, then advance to just after the next edge.
   task automatic cyc(input string tag, input logic [6:0] e);
      #1 chk(tag, {25'b0, o4}, {25'b0, e});
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      cyc("rst_c1", ORst);
      cyc("rst_c2", ORst);
      chk("rst_cnt", {16'b0, cnt4}, 32'd0);
      reset = 1'b0;
      cyc("run_after_rst", ORun);
      chk("cnt_after_rst", {16'b0, cnt4}, 32'd0);

      load_use_rs2(5'd5);
      cyc("loaduse", OLdUse);
      idle();
      cyc("loaduse_release", ORun);
      chk("cnt_loaduse", {16'b0, cnt4}, 32'd1);

      load_use_rs2(5'd0);
      cyc("loaduse_rd0", ORun);
      chk("cnt_rd0", {16'b0, cnt4}, 32'd1);

      idle();
      memRead_EX = 1'b1; rd_EX = 5'd7; rs1_ID = 5'd7; usesRs1_ID = 1'b0;
      cyc("rs1_unused", ORun);
      usesRs1_ID = 1'b1;
      cyc("loaduse_rs1", OLdUse);
      chk("cnt_rs1", {16'b0, cnt4}, 32'd2);

      idle();
      load_use_rs2(5'd5); branchTaken_EX = 1'b1;
      cyc("branch_over_loaduse", OBr);
      chk("cnt_branch", {16'b0, cnt4}, 32'd2);

      idle();
      load_use_rs2(5'd5); imemReady = 1'b0;
      cyc("loaduse_over_imem", OLdUse);
      chk("cnt_lu_imem", {16'b0, cnt4}, 32'd3);

      idle();
      muldivStart_EX = 1'b1;
      #1 chk("md2_c1", {25'b0, o2}, {25'b0, OMd});
      cyc("md4_c1", OMd);
      #1 chk("md2_c2_done", {25'b0, o2}, {25'b0, ODone});
      cyc("md4_c2", OMd);
      cyc("md4_c3", OMd);
      cyc("md4_c4_done", ODone);
      chk("cnt_md", {16'b0, cnt4}, 32'd6);
      idle();
      cyc("md_back_to_run", ORun);

      muldivStart_EX = 1'b1; imemReady = 1'b0;
      cyc("md_imem_c1", OMd);
      cyc("md_imem_c2", OMd);
      cyc("md_imem_c3", OMd);
      imemReady = 1'b1;
      cyc("md_imem_done", ODone);
      idle();
      imemReady = 1'b0;
      cyc("imem_alone", OImem);
      chk("cnt_imem", {16'b0, cnt4}, 32'd10);

      idle();
      muldivStart_EX = 1'b1;
      cyc("md_rst_c1", OMd);
      reset = 1'b1;
      cyc("md_rst_c2", ORst);
      reset = 1'b0; muldivStart_EX = 1'b0;
      cyc("md_rst_run1", ORun);
      cyc("md_rst_run2", ORun);
      cyc("md_rst_run3", ORun);
      chk("cnt_md_rst", {16'b0, cnt4}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage pipeline. It watches the ID and EX stages and the instruction-memory handshake, and drives the enable and clear inputs of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three hazards under a fixed priority: taken-branch redirects, multi-cycle mul/div occupancy of EX, and load-use dependencies. It also inserts bubbles while instruction fetch is not ready.

## Interface
- MULDIV_LATENCY, 4: total cycles a mul/div instruction occupies EX; legal values are ≥2.
- STALL_CNT_W, 16: width of the stall performance counter.

- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rs1_ID  in  5  source register 1 of the instruction in ID.
- rs2_ID  in  5  source register 2 of the instruction in ID.
- usesRs1_ID  in  1  ID instruction reads rs1.
- usesRs2_ID  in  1  ID instruction reads rs2.
- rd_EX  in  5  destination register of the instruction in EX.
- memRead_EX  in  1  the instruction in EX is a load.
- muldivStart_EX  in  1  the instruction in EX is mul/div.
- branchTaken_EX  in  1  EX resolved a taken branch or jump (PC redirect).
- imemReady  in  1  fetch data is valid this cycle.
- pcEnable  out  1  PC register load enable.
- ifidEnable  out  1  IF/ID enable.
- ifidClear  out  1  IF/ID clear (bubble).
- idexEnable  out  1  ID/EX enable.
- idexClear  out  1  ID/EX clear (bubble).
- exmemClear  out  1  EX/MEM clear (bubble).
- muldivDone  out  1  mul/div result is valid in EX this cycle.
- stallCount  out  STALL_CNT_W  count of cycles with pcEnable=0 since reset; wraps.

## Operation
- The FSM has three states: RUN, MD_BUSY and MD_RELEASE. A down-counter `mdRemain` is $clog2(MULDIV_LATENCY) bits wide, minimum 1.
- Signals:
  - loadUse = memRead_EX & (rd_EX≠0) & ((usesRs1_ID & rs1_ID==rd_EX) | (usesRs2_ID & rs2_ID==rd_EX)).
  - mdEntry = state==RUN & muldivStart_EX & !branchTaken_EX.
  - mdStall = mdEntry | state==MD_BUSY.
- Default outputs (no hazard): pcEnable=1, ifidEnable=1, idexEnable=1; all clears=0.
- Outputs are resolved in this priority order, highest first:
  1. **reset**: pcEnable=0, ifidEnable=0, idexEnable=0, ifidClear=1, idexClear=1, exmemClear=1, muldivDone=0.
  2. **branchTaken_EX**: pcEnable=1, ifidClear=1, idexClear=1. EX/MEM is not cleared because the branch itself retires. loadUse and imemReady are ignored.
  3. **mdStall**: pcEnable=0, ifidEnable=0, idexEnable=0, exmemClear=1. The ID/EX register is frozen, not cleared.
  4. **loadUse**: pcEnable=0, ifidEnable=0, idexClear=1. This stalls for one cycle; it self-releases once the load moves to MEM.
  5. **!imemReady**: pcEnable=0, ifidClear=1. Downstream stages advance.
- FSM transitions:
  - RUN, on mdEntry: go to MD_BUSY with mdRemain=MULDIV_LATENCY-2 if MULDIV_LATENCY>2; otherwise go to MD_RELEASE.
  - MD_BUSY: if mdRemain==1, go to MD_RELEASE; otherwise decrement mdRemain.
  - MD_RELEASE: assert muldivDone=1 with no stall, then go to RUN unconditionally. muldivStart_EX is ignored in this state because the same instruction is still in EX.
  - muldivStart_EX is ignored in MD_BUSY.
- The total mul/div stall is MULDIV_LATENCY-1 cycles. EX occupancy is MULDIV_LATENCY cycles.
- stallCount increments each cycle that pcEnable=0 and reset=0. It wraps from all-ones to 0.

## Timing
- All hazard outputs are combinational from the current state and inputs. There is no added latency: a stall or flush takes effect at the same clock edge at which the hazard is visible.
- State, mdRemain and stallCount update on the rising edge of clk.
- Reset values: state=RUN, mdRemain=0, stallCount=0. Output values during reset are as listed in priority 1.
- Reset asserted mid-mul/div: the FSM returns to RUN on the next edge, and no muldivDone is issued.
- Simultaneous events:
  - branchTaken_EX with loadUse: branch wins, and no stall cycle is counted.
  - mdStall with !imemReady: mdStall wins, and IF/ID is held, not cleared.
  - loadUse with !imemReady: loadUse wins, and IF/ID is held.
- Back-to-back mul/div: the second instruction enters EX the cycle after MD_RELEASE, the FSM is in RUN, and a fresh mdEntry occurs.

## Test plan
- Reset high for 2 cycles, then low with no hazards: during reset, clears=1 and enables=0. From the first cycle after reset, pcEnable=ifidEnable=idexEnable=1, clears=0, stallCount=0.
- memRead_EX=1, rd_EX=5, rs2_ID=5, usesRs2_ID=1 for one cycle: pcEnable=0, ifidEnable=0, idexClear=1 for exactly 1 cycle, then stallCount=1. Repeat with rd_EX=0: no stall.
- Same load-use as above plus branchTaken_EX=1: pcEnable=1, ifidClear=1, idexClear=1, and stallCount is unchanged.
- MULDIV_LATENCY=4, muldivStart_EX held high for 4 cycles: stall is asserted in cycles 1–3 with exmemClear=1. In cycle 4, muldivDone=1 with no stall. stallCount=3. Repeat with MULDIV_LATENCY=2: 1 stall cycle, and muldivDone=1 in cycle 2.
- imemReady=0 for 3 cycles during a mul/div stall, then alone: during the mul/div stall, IF/ID is held and ifidClear=0. When imemReady=0 alone, ifidClear=1 and pcEnable=0.
- Reset asserted in the 2nd cycle of a mul/div: the next cycle is in RUN, muldivDone never pulses, and stallCount=0.
